// File: rtl/grf_pkg.sv
// Shared constants for the scoreboarded general register file.
package grf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PEND_W_DEF = 2;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/grf_sb_cnt.sv
// Per-register in-flight-write counter: +1 on issue, -1 on write, clamped at both ends.
import grf_pkg::*;

module grf_sb_cnt #(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q = '0;
  logic [PEND_W-1:0] cnt_d;

  // inc and dec together cancel; dec at zero is an untracked write
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/grf_sb.sv
// Register file with write bypass and per-register pending-write scoreboard.
// Define GRF_TRACE_EN to print a trace line on every effective write.
import grf_pkg::*;

module grf_sb #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       pc,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready
);
  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO    = ADDR_W'(ZERO_REG);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [PEND_W-1:0] cnt    [DEPTH];
  logic              wr_hit;
  logic              iss_acc;

  assign wr_hit  = we && (wa != ZERO);
  assign iss_acc = iss_valid && iss_ready && (iss_addr != ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign cnt[0] = '0;

  genvar g;
  generate
    for (g = 1; g < DEPTH; g++) begin : g_cnt
      grf_sb_cnt #(.PEND_W(PEND_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (iss_acc && (iss_addr == ADDR_W'(g))),
        .dec   (we && (wa == ADDR_W'(g))),
        .cnt   (cnt[g])
      );
    end
  endgenerate

  // A same-cycle write to a full entry frees a slot, so the issue may proceed
  assign iss_ready = !((iss_addr != ZERO) && (cnt[iss_addr] == CNT_MAX) &&
                       !(we && (wa == iss_addr)));

  always_comb begin
    rd1   = (ra1 == ZERO) ? '0 : regs_q[ra1];
    rd2   = (ra2 == ZERO) ? '0 : regs_q[ra2];
    if (wr_hit && (wa == ra1)) rd1 = wd;
    if (wr_hit && (wa == ra2)) rd2 = wd;
    busy1 = (ra1 != ZERO) && (cnt[ra1] != '0) &&
            !(we && (wa == ra1) && (cnt[ra1] == CNT_ONE));
    busy2 = (ra2 != ZERO) && (cnt[ra2] != '0) &&
            !(we && (wa == ra2) && (cnt[ra2] == CNT_ONE));
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && wr_hit) $display("@%h: $%d <= %h", pc, wa, wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif
endmodule

// File: tb/tb_grf_sb.sv
// Self-checking bench for grf_sb: write data is queued as expected and popped on read-back.
module tb_grf_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa, iss_addr;
  logic [31:0] rd1, rd2, wd, pc;
  logic        busy1, busy2, we, iss_valid, iss_ready;

  typedef struct { logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t sbq[$];
  exp_t e, e2;
  int checks = 0;
  int errors = 0;

  grf_sb dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd), .pc(pc),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; pc = '0; iss_valid = 1'b0; iss_addr = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    if (a != 5'd0) sbq.push_back('{a: a, d: d});
  endtask

  task automatic test_reset();
    idle(); ra1 = 5'd3; ra2 = 5'd0; reset = 1'b0;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL init_rd1 got %h exp 0", rd1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL init_busy1 got %b exp 0", busy1); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL rst_iss_ready got %b exp 1", iss_ready); end
  endtask

  task automatic test_write_read();
    wr(5'd3, 32'h1234ABCD); pc = 32'h3000; tick(); idle();
    e = sbq.pop_front(); ra1 = e.a; #1;
    checks++; if (rd1 !== e.d) begin errors++; $display("FAIL wr_rd got %h exp %h", rd1, e.d); end
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 32'hFFFFFFFF); ra1 = 5'd0; #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_same got %h exp 0", rd1); end
    tick(); idle(); iss_valid = 1'b1; iss_addr = 5'd0; #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_next got %h exp 0", rd1); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL zero_iss_ready got %b exp 1", iss_ready); end
    tick(); idle(); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy1); end
  endtask

  task automatic test_bypass();
    wr(5'd7, 32'h55); ra2 = 5'd7; #1;
    checks++; if (rd2 !== 32'h55) begin errors++; $display("FAIL bypass got %h exp 55", rd2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL bypass_busy got %b exp 0", busy2); end
    tick(); idle();
    e = sbq.pop_front(); ra2 = e.a; #1;
    checks++; if (rd2 !== e.d) begin errors++; $display("FAIL bypass_held got %h exp %h", rd2, e.d); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1; iss_addr = 5'd5; #1;
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_fill%0d got %b exp 1", i, iss_ready); end
      tick();
    end
    idle(); ra1 = 5'd5; iss_valid = 1'b1; iss_addr = 5'd5; #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %b exp 0", iss_ready); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sat_busy got %b exp 1", busy1); end
    wr(5'd5, 32'hA0); #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_wr_iss got %b exp 1", iss_ready); end
    tick(); idle(); iss_valid = 1'b1; iss_addr = 5'd5; #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_still_full got %b exp 0", iss_ready); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sat_still_busy got %b exp 1", busy1); end
    void'(sbq.pop_front());
    for (int i = 0; i < 3; i++) begin
      idle(); wr(5'd5, 32'hB0 + i); #1;
      checks++; if (busy1 !== (i < 2)) begin errors++; $display("FAIL drain%0d busy got %b exp %b", i, busy1, i < 2); end
      tick();
      if (i < 2) void'(sbq.pop_front());
    end
    idle(); e = sbq.pop_front(); ra1 = e.a; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL drained_busy got %b exp 0", busy1); end
    checks++; if (rd1 !== e.d) begin errors++; $display("FAIL drained_rd got %h exp %h", rd1, e.d); end
  endtask

  task automatic test_busy_clear();
    iss_valid = 1'b1; iss_addr = 5'd9; tick(); idle(); ra1 = 5'd9; #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL bc_pending got %b exp 1", busy1); end
    wr(5'd9, 32'h99); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL bc_wr_cycle got %b exp 0", busy1); end
    checks++; if (rd1 !== 32'h99) begin errors++; $display("FAIL bc_rd got %h exp 99", rd1); end
    tick(); idle(); e = sbq.pop_front(); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL bc_after got %b exp 0", busy1); end
    checks++; if (rd1 !== e.d) begin errors++; $display("FAIL bc_held got %h exp %h", rd1, e.d); end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_addr = 5'd4; tick(); tick();
    reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hDEAD; tick();
    reset = 1'b0; idle(); sbq.delete();
    ra1 = 5'd4; ra2 = 5'd3; iss_valid = 1'b1; iss_addr = 5'd4; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy1); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rm_rd1 got %h exp 0", rd1); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rm_rd2 got %h exp 0", rd2); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL rm_iss_ready got %b exp 1", iss_ready); end
    tick(); idle(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 30; a++) begin
      idle(); wr(5'(a), $urandom()); tick();
    end
    idle();
    while (sbq.size() >= 2) begin
      e = sbq.pop_front(); e2 = sbq.pop_front();
      ra1 = e.a; ra2 = e2.a; #1;
      checks++; if (rd1 !== e.d) begin errors++; $display("FAIL b2b_rd1[%0d] got %h exp %h", e.a, rd1, e.d); end
      checks++; if (rd2 !== e2.d) begin errors++; $display("FAIL b2b_rd2[%0d] got %h exp %h", e2.a, rd2, e2.d); end
      checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL b2b_busy[%0d] got %b%b exp 00", e.a, busy1, busy2); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_saturate();
    test_busy_clear();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grf_sb.md
GRF_SB -- requirements
Module: grf_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter PEND_W, default 2, width of each per-register in-flight-write counter.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 ra1, ra2  input  ADDR_W each  read addresses.
REQ-007 rd1, rd2  output  DATA_W each  read data, combinational.
REQ-008 busy1, busy2  output  1 each  a pending write targets ra1/ra2 and will not complete this cycle.
REQ-009 we  input  1  write enable; wa  input  ADDR_W  write address; wd  input  DATA_W  write data.
REQ-010 pc  input  32  PC of the writing instruction, used only for tracing.
REQ-011 iss_valid  input  1  issue request for an instruction with a destination; iss_addr  input  ADDR_W.
REQ-012 iss_ready  output  1  issue accepted this cycle when iss_valid && iss_ready.

Function
REQ-013 Register 0 SHALL read as 0 always; writes and issues to address 0 SHALL be ignored (no counter change, no trace).
REQ-014 Write: on posedge clk with we=1 and wa!=0, reg[wa] <= wd.
REQ-015 Bypass: if we=1, wa!=0 and wa==raN, rdN SHALL equal wd in the same cycle; otherwise rdN = reg[raN].
REQ-016 Scoreboard: cnt[x] increments by 1 on an accepted issue to x, decrements by 1 on a write (we=1) to x.
REQ-017 Simultaneous accepted issue and write to the same x: cnt[x] SHALL be unchanged.
REQ-018 A write to x with cnt[x]==0 (untracked write) SHALL update the register and leave cnt[x] at 0 (no underflow).
REQ-019 iss_ready SHALL be 0 when iss_addr!=0 and cnt[iss_addr]==2**PEND_W-1 and no write to iss_addr occurs this cycle; 1 otherwise.
REQ-020 busyN = (raN!=0) && (cnt[raN]!=0) && !(we && wa==raN && cnt[raN]==1).
REQ-021 Issue and read in the same cycle: busyN SHALL reflect counter state before the issue (issue takes effect next cycle).
REQ-022 Counters SHALL never wrap: saturation is prevented solely by iss_ready=0.

Reset
REQ-023 On reset=1 at posedge clk: all registers <= 0, all cnt <= 0; write and issue inputs that cycle are ignored.
REQ-024 Reset mid-operation SHALL drop all pending state; busy1/busy2 = 0 and iss_ready = 1 from the next cycle.
REQ-025 Registers and counters SHALL also initialise to 0 at simulation start.

Configuration
REQ-026 Macro GRF_TRACE_EN: when defined, every effective write (REQ-014) SHALL $display "@%h: $%d <= %h" with pc, wa, wd at the clock edge.
REQ-027 Without GRF_TRACE_EN: no display; pc port present but unused; functional behaviour identical.

Structure
REQ-028 Shared package grf_pkg SHALL hold default DATA_W/ADDR_W/PEND_W constants and the ZERO_REG address constant.
REQ-029 One sub-module grf_sb_cnt SHALL implement a single per-register saturating up/down counter, instantiated DEPTH-1 times (none for register 0).

Verification
REQ-030 Write wa=3, wd=0x1234ABCD, pc=0x3000; next cycle ra1=3 -> rd1=0x1234ABCD; trace "@00003000: $ 3 <= 1234abcd" only with GRF_TRACE_EN.
REQ-031 we=1, wa=0, wd=0xFFFFFFFF; ra1=0 -> rd1=0 same and next cycle; issue to 0 -> busy1 stays 0.
REQ-032 we=1, wa=7, wd=0x55 with ra2=7 in the same cycle -> rd2=0x55 combinationally.
REQ-033 Issue to 5 three times (PEND_W=2) -> cnt=3, iss_ready=0 for iss_addr=5, busy1=1 at ra1=5; write 5 with issue 5 same cycle -> accepted, cnt stays 3.
REQ-034 Issue to 9 once, next cycle we=1 wa=9 with ra1=9 -> busy1=0 in that cycle, rd1=wd; following cycle busy1=0.
REQ-035 Issue to 4 twice, then reset=1 one cycle -> all reads 0, busy1=0 at ra1=4, iss_ready=1.
